button_sequencer: RTL

//  Synthesisable button-press sequencer for the calculator core. It queues

---
 rtl/button_sequencer.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/button_sequencer.sv
// Calculator button codes plus a paced press sequencer: queued codes are replayed
// as one-hot presses of PressCycles cycles, each followed by GapCycles released cycles.
package calc_pkg;

    typedef enum logic [4:0] {
        B_NONE   = 5'd0,
        B_NUM_0  = 5'd1,
        B_NUM_1  = 5'd2,
        B_NUM_2  = 5'd3,
        B_NUM_3  = 5'd4,
        B_NUM_4  = 5'd5,
        B_NUM_5  = 5'd6,
        B_NUM_6  = 5'd7,
        B_NUM_7  = 5'd8,
        B_NUM_8  = 5'd9,
        B_NUM_9  = 5'd10,
        B_OP_ADD = 5'd11,
        B_OP_SUB = 5'd12,
        B_OP_MUL = 5'd13,
        B_OP_DIV = 5'd14,
        B_OP_EQ  = 5'd15,
        B_CLEAR  = 5'd16,
        B_ON     = 5'd17
    } active_button_t;

    typedef struct packed {
        logic on;
        logic clear;
        logic op_eq;
        logic op_div;
        logic op_mul;
        logic op_sub;
        logic op_add;
        logic num_9;
        logic num_8;
        logic num_7;
        logic num_6;
        logic num_5;
        logic num_4;
        logic num_3;
        logic num_2;
        logic num_1;
        logic num_0;
    } buttons_t;

    // Codes outside the table (including B_NONE) map to no button at all.
    function automatic buttons_t to_buttons(input active_button_t code);
        buttons_t b;
        b = '0;
        case (code)
            B_NUM_0:  b.num_0  = 1'b1;
            B_NUM_1:  b.num_1  = 1'b1;
            B_NUM_2:  b.num_2  = 1'b1;
            B_NUM_3:  b.num_3  = 1'b1;
            B_NUM_4:  b.num_4  = 1'b1;
            B_NUM_5:  b.num_5  = 1'b1;
            B_NUM_6:  b.num_6  = 1'b1;
            B_NUM_7:  b.num_7  = 1'b1;
            B_NUM_8:  b.num_8  = 1'b1;
            B_NUM_9:  b.num_9  = 1'b1;
            B_OP_ADD: b.op_add = 1'b1;
            B_OP_SUB: b.op_sub = 1'b1;
            B_OP_MUL: b.op_mul = 1'b1;
            B_OP_DIV: b.op_div = 1'b1;
            B_OP_EQ:  b.op_eq  = 1'b1;
            B_CLEAR:  b.clear  = 1'b1;
            B_ON:     b.on     = 1'b1;
            default:  b        = '0;
        endcase
        return b;
    endfunction

endpackage

module button_sequencer
    import calc_pkg::*;
#(
    parameter int Depth       = 8,
    parameter int PressCycles = 4,
    parameter int GapCycles   = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       button_valid_i,
    input  active_button_t             button_i,
    output logic                       button_ready_o,
    input  logic                       flush_i,
    output buttons_t                   buttons_o,
    output logic                       pressing_o,
    output logic                       busy_o,
    output logic [$clog2(Depth+1)-1:0] count_o
);

    localparam int AW   = $clog2(Depth);
    localparam int CW   = $clog2(Depth + 1);
    localparam int TMax = (PressCycles > GapCycles) ? PressCycles : GapCycles;
    localparam int TW   = (TMax > 1) ? $clog2(TMax) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRESS,
        S_GAP
    } state_t;

    active_button_t mem_q [Depth];
    logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]  count_q;
    state_t         state_q, state_d;
    logic [TW-1:0]  timer_q, timer_d;
    buttons_t       buttons_q, buttons_d;
    logic           full, empty, push, pop;
    active_button_t head_code, next_code;

    assign full      = (count_q == CW'(Depth));
    assign empty     = (count_q == '0);
    // A full FIFO refuses pushes even when the head retires on the same edge.
    assign push      = button_valid_i && !full && !flush_i;
    assign head_code = mem_q[rd_ptr_q];
    assign next_code = mem_q[rd_ptr_q + AW'(1)];

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= button_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            timer_q   <= '0;
            buttons_q <= '0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            buttons_q <= buttons_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        buttons_d = buttons_q;
        pop       = 1'b0;
        if (flush_i) begin
            state_d   = S_IDLE;
            timer_d   = '0;
            buttons_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!empty) begin
                        state_d   = S_PRESS;
                        timer_d   = TW'(PressCycles - 1);
                        buttons_d = to_buttons(head_code);
                    end
                end
                S_PRESS: begin
                    if (timer_q == '0) begin
                        state_d   = S_GAP;
                        timer_d   = TW'(GapCycles - 1);
                        buttons_d = '0;
                    end else begin
                        timer_d = timer_q - TW'(1);
                    end
                end
                S_GAP: begin
                    if (timer_q == '0) begin
                        pop = 1'b1;
                        // Chain straight into the next press when another entry waits.
                        if (count_q > CW'(1)) begin
                            state_d   = S_PRESS;
                            timer_d   = TW'(PressCycles - 1);
                            buttons_d = to_buttons(next_code);
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        timer_d = timer_q - TW'(1);
                    end
                end
                default: begin
                    state_d   = S_IDLE;
                    timer_d   = '0;
                    buttons_d = '0;
                end
            endcase
        end
    end

    assign buttons_o      = buttons_q;
    assign pressing_o     = (state_q == S_PRESS);
    assign busy_o         = (state_q != S_IDLE) || !empty;
    assign button_ready_o = !full;
    assign count_o        = count_q;

endmodule
